fib_bcd_converter: RTL

Downstream consumer of the 12-bit Fibonacci sequence generator. Accepts one binary term per valid/ready handshake and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per cycle. Presents the result on a valid/ready output for the display/driver stage. Optionally flags when the 12-bit sequence has wrapped modulo 4096.

---
 rtl/fib_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 15 +
 rtl/fib_bcd_converter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared constants and FSM state type for the Fibonacci BCD display path.
package fib_pkg;

  // Default binary term width; matches the Fibonacci generator output.
  localparam int unsigned FibWidth    = 12;
  // Default BCD digit count; 10^FibDigits must exceed 2^FibWidth-1.
  localparam int unsigned FibDigits   = 4;
  // Iteration counter width; the counter must be able to hold FibWidth.
  localparam int unsigned FibCntWidth = $clog2(FibWidth + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } fib_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // 4-bit unsigned add; the result cannot exceed 12 for a valid digit.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/fib_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle, with
// valid/ready handshakes on both sides.
// Optional feature macro: FIB_WRAP_DETECT_EN (flags a term smaller than the
// previously accepted one, i.e. a modulo-2^WIDTH wrap of the sequence).
module fib_bcd_converter
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH  = FibWidth,
  parameter int unsigned DIGITS = FibDigits
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_wrap
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  fib_state_e        state_q, state_d;
  logic [SrW-1:0]    sr_q, sr_d, sr_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              accept;
  logic              finish;

  // Binary bits pass through untouched; only the BCD digits are corrected.
  assign sr_adj[WIDTH-1:0] = sr_q[WIDTH-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
    bcd_digit_adj u_adj (
      .digit_i (sr_q[WIDTH+4*g +: 4]),
      .digit_o (sr_adj[WIDTH+4*g +: 4])
    );
  end

  assign accept = (state_q == StIdle) && in_valid;
  assign finish = (state_q == StShift) && (cnt_q == CntW'(WIDTH - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sr_d    = {{BcdW{1'b0}}, in_data};
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d  = {sr_adj[SrW-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (finish) begin
          bcd_d   = sr_d[SrW-1 -: BcdW];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, shift register, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_bcd   = bcd_q;

`ifdef FIB_WRAP_DETECT_EN
  logic [WIDTH-1:0] prev_q;
  logic             wrap_pend_q;
  logic             wrap_q;

  // Wrap flag is captured at acceptance and published with its BCD result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      wrap_pend_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      if (accept) begin
        prev_q      <= in_data;
        wrap_pend_q <= (in_data < prev_q);
      end
      if (finish) begin
        wrap_q <= wrap_pend_q;
      end
    end
  end

  assign out_wrap = wrap_q;
`else
  assign out_wrap = 1'b0;
`endif

endmodule
